// File: rtl/tdm_demux4.sv
// tdm_demux4 -- 4-channel TDM demultiplexer with sof-based framing.
// Revision: 1.0
`default_nettype none

module tdm_demux4 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_vld,
   input  logic         sof,
   input  logic         err_clr,
   output logic [W-1:0] q0,
   output logic [W-1:0] q1,
   output logic [W-1:0] q2,
   output logic [W-1:0] q3,
   output logic [3:0]   q_stb,
   output logic         frame_done,
   output logic         locked,
   output logic         sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t     state;
   logic [1:0] ch;

   // locked comes straight off the state flop, so it has no input path.
   assign locked = (state == LOCKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         ch         <= 2'd0;
         q0         <= '0;
         q1         <= '0;
         q2         <= '0;
         q3         <= '0;
         q_stb      <= 4'b0000;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         q_stb      <= 4'b0000;
         frame_done <= 1'b0;
         // Clear first so that a same-cycle error set below takes priority.
         if (err_clr) begin
            sync_err <= 1'b0;
         end
         if (din_vld) begin
            case (state)
               HUNT: begin
                  if (sof) begin
                     q0    <= din;
                     q_stb <= 4'b0001;
                     ch    <= 2'd1;
                     state <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (sof) begin
                     q0    <= din;
                     q_stb <= 4'b0001;
                     ch    <= 2'd1;
                     if (ch != 2'd0) begin
                        sync_err <= 1'b1;
                     end
                  end else if (ch == 2'd0) begin
                     sync_err <= 1'b1;
                     state    <= HUNT;
                  end else begin
                     case (ch)
                        2'd1:    q1 <= din;
                        2'd2:    q2 <= din;
                        default: q3 <= din;
                     endcase
                     q_stb <= 4'b0001 << ch;
                     ch    <= ch + 2'd1;
                     if (ch == 2'd3) begin
                        frame_done <= 1'b1;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- self-checking bench for tdm_demux4.
// Revision: 1.0
`default_nettype none

module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_vld = 1'b0;
   logic       sof = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] q0, q1, q2, q3;
   logic [3:0] q_stb;
   logic       frame_done, locked, sync_err;

   int n_cmp  = 0;
   int n_fail = 0;

   tdm_demux4 #(.W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
      .err_clr(err_clr), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
      .q_stb(q_stb), .frame_done(frame_done), .locked(locked),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic       sf;
      logic       clr;
      logic [7:0] d;
      logic [7:0] e0, e1, e2, e3;
      logic [3:0] estb;
      logic       efd, elk, eerr;
   } vec_t;

   vec_t tbl[15];

   // Behavioural reference: pos = index of the next expected channel, -1 = hunting.
   logic [7:0] m_q[4];
   logic [3:0] m_stb;
   logic       m_fd, m_err;
   int         m_pos;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] estb,
                          input logic efd, input logic elk, input logic eerr);
      chk({tag, ".q0"}, 32'(q0), 32'(e0));
      chk({tag, ".q1"}, 32'(q1), 32'(e1));
      chk({tag, ".q2"}, 32'(q2), 32'(e2));
      chk({tag, ".q3"}, 32'(q3), 32'(e3));
      chk({tag, ".q_stb"}, 32'(q_stb), 32'(estb));
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
      chk({tag, ".locked"}, 32'(locked), 32'(elk));
      chk({tag, ".sync_err"}, 32'(sync_err), 32'(eerr));
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic c);
      din_vld = v; sof = s; din = d; err_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din_vld = 1'b0; sof = 1'b0; err_clr = 1'b0; din = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_q[i] = 8'h00;
      m_stb = 4'b0; m_fd = 1'b0; m_err = 1'b0; m_pos = -1;
   endtask

   task automatic model_step(input logic v, input logic s, input logic [7:0] d, input logic c);
      m_stb = 4'b0;
      m_fd  = 1'b0;
      if (c) m_err = 1'b0;
      if (v) begin
         if (m_pos < 0) begin
            if (s) begin m_q[0] = d; m_stb = 4'b0001; m_pos = 1; end
         end else if (s) begin
            if (m_pos != 0) m_err = 1'b1;
            m_q[0] = d; m_stb = 4'b0001; m_pos = 1;
         end else if (m_pos == 0) begin
            m_err = 1'b1; m_pos = -1;
         end else begin
            m_q[m_pos] = d;
            m_stb = 4'(1 << m_pos);
            m_fd  = (m_pos == 3);
            m_pos = (m_pos + 1) % 4;
         end
      end
   endtask

   initial begin
      // Nominal frame, early sof, missing sof and err_clr priority.
      tbl[0]  = '{1'b1,1'b1,1'b0,8'h11, 8'h11,8'h00,8'h00,8'h00, 4'b0001,1'b0,1'b1,1'b0};
      tbl[1]  = '{1'b1,1'b0,1'b0,8'h22, 8'h11,8'h22,8'h00,8'h00, 4'b0010,1'b0,1'b1,1'b0};
      tbl[2]  = '{1'b1,1'b0,1'b0,8'h33, 8'h11,8'h22,8'h33,8'h00, 4'b0100,1'b0,1'b1,1'b0};
      tbl[3]  = '{1'b1,1'b0,1'b0,8'h44, 8'h11,8'h22,8'h33,8'h44, 4'b1000,1'b1,1'b1,1'b0};
      tbl[4]  = '{1'b1,1'b1,1'b0,8'h11, 8'h11,8'h22,8'h33,8'h44, 4'b0001,1'b0,1'b1,1'b0};
      tbl[5]  = '{1'b1,1'b0,1'b0,8'h22, 8'h11,8'h22,8'h33,8'h44, 4'b0010,1'b0,1'b1,1'b0};
      tbl[6]  = '{1'b1,1'b1,1'b0,8'h55, 8'h55,8'h22,8'h33,8'h44, 4'b0001,1'b0,1'b1,1'b1};
      tbl[7]  = '{1'b1,1'b0,1'b0,8'h66, 8'h55,8'h66,8'h33,8'h44, 4'b0010,1'b0,1'b1,1'b1};
      tbl[8]  = '{1'b1,1'b0,1'b0,8'h33, 8'h55,8'h66,8'h33,8'h44, 4'b0100,1'b0,1'b1,1'b1};
      tbl[9]  = '{1'b1,1'b0,1'b0,8'h44, 8'h55,8'h66,8'h33,8'h44, 4'b1000,1'b1,1'b1,1'b1};
      tbl[10] = '{1'b1,1'b0,1'b0,8'h77, 8'h55,8'h66,8'h33,8'h44, 4'b0000,1'b0,1'b0,1'b1};
      tbl[11] = '{1'b0,1'b0,1'b1,8'h00, 8'h55,8'h66,8'h33,8'h44, 4'b0000,1'b0,1'b0,1'b0};
      tbl[12] = '{1'b1,1'b1,1'b0,8'h11, 8'h11,8'h66,8'h33,8'h44, 4'b0001,1'b0,1'b1,1'b0};
      tbl[13] = '{1'b1,1'b1,1'b1,8'h55, 8'h55,8'h66,8'h33,8'h44, 4'b0001,1'b0,1'b1,1'b1};
      tbl[14] = '{1'b0,1'b0,1'b0,8'hFF, 8'h55,8'h66,8'h33,8'h44, 4'b0000,1'b0,1'b1,1'b1};

      do_reset();
      chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].vld, tbl[i].sf, tbl[i].d, tbl[i].clr);
         chk_all($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3,
                 tbl[i].estb, tbl[i].efd, tbl[i].elk, tbl[i].eerr);
      end

      // Idle gaps between words.
      do_reset();
      begin
         logic [7:0] w[4];
         logic [7:0] e[4];
         w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
         for (int k = 0; k < 4; k++) e[k] = 8'h00;
         for (int k = 0; k < 4; k++) begin
            cyc(1'b1, k == 0, w[k], 1'b0);
            e[k] = w[k];
            chk_all($sformatf("gap_w%0d", k), e[0], e[1], e[2], e[3],
                    4'(1 << k), k == 3, 1'b1, 1'b0);
            for (int g = 0; g < 3; g++) begin
               cyc(1'b0, 1'b1, 8'hEE, 1'b0);
               chk_all($sformatf("gap_idle%0d_%0d", k, g), e[0], e[1], e[2], e[3],
                       4'b0000, 1'b0, 1'b1, 1'b0);
            end
         end
      end

      // HUNT discards words without sof.
      do_reset();
      cyc(1'b1, 1'b0, 8'hAA, 1'b0);
      chk_all("hunt_aa", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'hBB, 1'b0);
      chk_all("hunt_bb", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(tbl[i].vld, tbl[i].sf, tbl[i].d, tbl[i].clr);
         chk_all($sformatf("hunt_f%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3,
                 tbl[i].estb, tbl[i].efd, tbl[i].elk, tbl[i].eerr);
      end

      // Asynchronous reset mid-frame, asserted between clock edges.
      do_reset();
      cyc(1'b1, 1'b1, 8'h11, 1'b0);
      cyc(1'b1, 1'b0, 8'h22, 1'b0);
      chk_all("arst_pre", 8'h11, 8'h22, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b1, 1'b0);
      din_vld = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_all("arst_async", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      cyc(1'b1, 1'b0, 8'h99, 1'b0);
      chk_all("arst_99", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h11, 1'b0);
      chk_all("arst_sof", 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 1'b0);

      // Randomised traffic against the reference model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic v, s, c;
         logic [7:0] d;
         v = ($urandom_range(0, 3) != 0);
         s = (m_pos == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
         c = ($urandom_range(0, 9) == 0);
         d = 8'($urandom);
         cyc(v, s, d, c);
         model_step(v, s, d, c);
         chk_all($sformatf("rnd%0d", n), m_q[0], m_q[1], m_q[2], m_q[3],
                 m_stb, m_fd, m_pos >= 0, m_err);
         chk("rnd_onehot", 32'($countones(q_stb) <= 1), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
